// File: rtl/led_pkg.sv
// Shared definitions for the LED frame path: frame geometry and arbiter state encoding.
package led_pkg;

  localparam int unsigned LED_BITS       = 24;
  localparam int unsigned LEDS_PER_FRAME = 4;
  localparam int unsigned FRAME_W        = LED_BITS * LEDS_PER_FRAME;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    RET   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr, wrapping.
module led_rr_pick
  import led_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Walk offsets from the far end so the closest asserted request is written last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_SRC)) begin
        sum = sum - (IDX_W + 1)'(NUM_SRC);
      end
      idx = sum[IDX_W-1:0];
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_frame_arbiter.sv
// Round-robin owner of the single WS2812B output path; latches one frame per grant.
module led_frame_arbiter
  import led_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned FRAME_W   = led_pkg::FRAME_W,
  parameter int unsigned FRAME_GAP = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*FRAME_W-1:0] frameData,
  input  logic                       sendDone,
  input  logic                       retDone,
  output logic [NUM_SRC-1:0]         grant,
  output logic [FRAME_W-1:0]         frameOut,
  output logic                       go,
  output logic [NUM_SRC-1:0]         ack,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned GAP_W = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

  arb_state_e       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] ptr_q;
  logic [GAP_W-1:0] gap_q;
  logic [IDX_W-1:0] winner;
  logic             found;

  led_rr_pick #(
    .NUM_SRC(NUM_SRC),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(winner),
    .found (found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      gap_q    <= '0;
      grant    <= '0;
      frameOut <= '0;
      go       <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
    end else begin
      ack <= '0;
      if (gap_q != '0) begin
        gap_q <= gap_q - GAP_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (found && (gap_q == '0) && retDone) begin
            owner_q <= winner;
            busy    <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          grant    <= NUM_SRC'(1) << owner_q;
          frameOut <= frameData[owner_q*FRAME_W +: FRAME_W];
          ptr_q    <= (owner_q == IDX_W'(NUM_SRC - 1)) ? '0 : owner_q + IDX_W'(1);
          go       <= 1'b1;
          state_q  <= SEND;
        end
        SEND: begin
          if (sendDone) begin
            go           <= 1'b0;
            ack[owner_q] <= 1'b1;
            // Loading here overrides the decrement so the gap starts at sendDone.
            gap_q        <= GAP_W'(FRAME_GAP);
            state_q      <= RET;
          end
        end
        RET: begin
          if (retDone) begin
            grant   <= '0;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Randomised self-checking bench for led_frame_arbiter against a timing/fairness model.
module tb_led_frame_arbiter;

  localparam int NS = 4;
  localparam int FW = 96;
  localparam int FG = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NS-1:0]    req = '0;
  logic [NS*FW-1:0] frame_data = '0;
  logic             send_done = 1'b0;
  logic             ret_done = 1'b1;
  logic [NS-1:0]    grant;
  logic [FW-1:0]    frame_out;
  logic             go;
  logic [NS-1:0]    ack;
  logic             busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;
  int last_s = -1000;
  int last_ret_exit = -1000;

  led_frame_arbiter #(
    .NUM_SRC  (NS),
    .FRAME_W  (FW),
    .FRAME_GAP(FG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .frameData(frame_data),
    .sendDone (send_done),
    .retDone  (ret_done),
    .grant    (grant),
    .frameOut (frame_out),
    .go       (go),
    .ack      (ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frames();
    for (int i = 0; i < NS * FW / 32; i++) frame_data[i*32 +: 32] = $urandom();
  endtask

  // First asserted source at or after p, wrapping.
  function automatic int rr_expect(input logic [NS-1:0] mask, input int p);
    for (int k = 0; k < NS; k++) begin
      if (mask[(p + k) % NS]) return (p + k) % NS;
    end
    return -1;
  endfunction

  // Grant becomes visible one edge after the first IDLE edge where req, gap and retDone allow it.
  function automatic int exp_grant_edge(input int e_req);
    int m;
    m = e_req + 1;
    if (last_s + FG + 1 > m) m = last_s + FG + 1;
    if (last_ret_exit + 1 > m) m = last_ret_exit + 1;
    return m + 1;
  endfunction

  task automatic run_frame(input logic [NS-1:0] mask, input bit drop_req, input bit scramble,
                           input int send_delay, input int ret_delay,
                           output int exp_edge, output int g_edge, output logic [NS-1:0] g,
                           output logic [FW-1:0] fo, output logic [NS*FW-1:0] fd_g,
                           output logic go_pre, output logic [FW-1:0] fo_end, output logic go_s,
                           output logic [NS-1:0] a, output logic [NS-1:0] a_after,
                           output int hold_bad);
    int n;
    int ret_from;
    hold_bad = 0;
    req = mask;
    exp_edge = exp_grant_edge(cyc);
    tick();
    n = 1;
    while (grant === '0 && n < 300) begin
      tick();
      n++;
    end
    g_edge = (grant !== '0) ? cyc : -1;
    g = grant;
    fo = frame_out;
    fd_g = frame_data;
    if (drop_req) req = '0;
    if (scramble) rand_frames();
    repeat (send_delay) tick();
    go_pre = go;
    fo_end = frame_out;
    send_done = 1'b1;
    ret_done = (ret_delay == 0);
    tick();
    a = ack;
    go_s = go;
    last_s = cyc;
    send_done = 1'b0;
    tick();
    a_after = ack;
    if (ret_delay > 0) begin
      repeat (ret_delay - 1) begin
        tick();
        if (grant !== g || go !== 1'b0) hold_bad++;
      end
      ret_done = 1'b1;
      ret_from = cyc + 1;
    end else begin
      ret_from = last_s;
    end
    last_ret_exit = (ret_from > last_s + 1) ? ret_from : last_s + 1;
    while (cyc < last_ret_exit) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (grant !== '0) begin failures++; $display("FAIL reset_grant got=%b want=0", grant); end
    checks++; if (frame_out !== '0) begin failures++; $display("FAIL reset_frame got=%h want=0", frame_out); end
    checks++; if (go !== 1'b0) begin failures++; $display("FAIL reset_go got=%b want=0", go); end
    checks++; if (ack !== '0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    reset = 1'b0;
    exp_ptr = 0;
    last_s = -1000;
    last_ret_exit = -1000;
  endtask

  task automatic test_single();
    int ee, ge, hb;
    logic [NS-1:0] g, a, a2;
    logic [FW-1:0] fo, foe, want;
    logic [NS*FW-1:0] fd;
    logic gp, gs;
    rand_frames();
    want = 96'hFF0000_00FF00_0000FF_FFFFFF;
    frame_data[0 +: FW] = want;
    run_frame(4'b0001, 1'b1, 1'b0, 5, 0, ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
    exp_ptr = 1;
    checks++; if (g !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b want=0001", g); end
    checks++; if (fo !== want) begin failures++; $display("FAIL single_frame got=%h want=%h", fo, want); end
    checks++; if (ge !== ee) begin failures++; $display("FAIL single_latency got=%0d want=%0d", ge, ee); end
    checks++; if (gp !== 1'b1) begin failures++; $display("FAIL single_go_high got=%b want=1", gp); end
    checks++; if (gs !== 1'b0) begin failures++; $display("FAIL single_go_low got=%b want=0", gs); end
    checks++; if (a !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b want=0001", a); end
    checks++; if (a2 !== 4'b0000) begin failures++; $display("FAIL single_ack_pulse got=%b want=0000", a2); end
  endtask

  task automatic test_fairness();
    int ee, ge, hb, w;
    int cnt[NS];
    logic [NS-1:0] g, a, a2;
    logic [FW-1:0] fo, foe;
    logic [NS*FW-1:0] fd;
    logic gp, gs;
    for (int k = 0; k < NS; k++) cnt[k] = 0;
    for (int f = 0; f < 2 * NS; f++) begin
      w = rr_expect(4'b1111, exp_ptr);
      run_frame(4'b1111, 1'b0, 1'b0, 2, 0, ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
      exp_ptr = (w + 1) % NS;
      for (int k = 0; k < NS; k++) if (a[k]) cnt[k]++;
      checks++;
      if (g !== (4'b0001 << w)) begin
        failures++; $display("FAIL fair_grant frame=%0d got=%b want_src=%0d", f, g, w);
      end
      checks++;
      if (ge !== ee) begin failures++; $display("FAIL fair_timing frame=%0d got=%0d want=%0d", f, ge, ee); end
    end
    for (int k = 0; k < NS; k++) begin
      checks++;
      if (cnt[k] != 2) begin failures++; $display("FAIL fair_acks src=%0d got=%0d want=2", k, cnt[k]); end
    end
  endtask

  task automatic test_gap();
    int ee, ge, hb, prev_s;
    logic [NS-1:0] g, a, a2;
    logic [FW-1:0] fo, foe;
    logic [NS*FW-1:0] fd;
    logic gp, gs;
    for (int f = 0; f < 2; f++) begin
      prev_s = last_s;
      run_frame(4'b0010, 1'b0, 1'b0, 1, 0, ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
      exp_ptr = 2;
      checks++;
      if (ge - prev_s < FG + 1) begin
        failures++; $display("FAIL gap_min frame=%0d got=%0d want>=%0d", f, ge - prev_s, FG + 1);
      end
      checks++;
      if (ge !== ee) begin failures++; $display("FAIL gap_edge frame=%0d got=%0d want=%0d", f, ge, ee); end
    end
    req = '0;
  endtask

  task automatic test_stability();
    int ee, ge, hb;
    logic [NS-1:0] g, a, a2;
    logic [FW-1:0] fo, foe;
    logic [NS*FW-1:0] fd;
    logic gp, gs;
    rand_frames();
    run_frame(4'b0100, 1'b1, 1'b1, 4, 0, ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
    exp_ptr = 3;
    checks++; if (g !== 4'b0100) begin failures++; $display("FAIL stab_grant got=%b want=0100", g); end
    checks++;
    if (foe !== fd[2*FW +: FW]) begin
      failures++; $display("FAIL stab_frame got=%h want=%h", foe, fd[2*FW +: FW]);
    end
    checks++; if (a !== 4'b0100) begin failures++; $display("FAIL stab_ack got=%b want=0100", a); end
  endtask

  task automatic test_ret_hold();
    int ee, ge, hb, w;
    logic [NS-1:0] g, a, a2;
    logic [FW-1:0] fo, foe;
    logic [NS*FW-1:0] fd;
    logic gp, gs;
    w = rr_expect(4'b1111, exp_ptr);
    run_frame(4'b1111, 1'b0, 1'b0, 1, 50, ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
    exp_ptr = (w + 1) % NS;
    checks++; if (hb != 0) begin failures++; $display("FAIL ret_hold bad_cycles got=%0d want=0", hb); end
    w = rr_expect(4'b1111, exp_ptr);
    run_frame(4'b1111, 1'b1, 1'b0, 1, 0, ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
    exp_ptr = (w + 1) % NS;
    checks++; if (ge !== ee) begin failures++; $display("FAIL ret_regrant got=%0d want=%0d", ge, ee); end
    checks++;
    if (g !== (4'b0001 << w)) begin failures++; $display("FAIL ret_grant got=%b want_src=%0d", g, w); end
  endtask

  task automatic test_random();
    int ee, ge, hb, w;
    logic [NS-1:0] g, a, a2, mask;
    logic [FW-1:0] fo, foe;
    logic [NS*FW-1:0] fd;
    logic gp, gs;
    for (int f = 0; f < 20; f++) begin
      mask = NS'($urandom_range(1, 15));
      rand_frames();
      w = rr_expect(mask, exp_ptr);
      run_frame(mask, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                $urandom_range(0, 4), ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
      exp_ptr = (w + 1) % NS;
      checks++;
      if (g !== (4'b0001 << w)) begin
        failures++; $display("FAIL rnd_grant frame=%0d got=%b want_src=%0d", f, g, w);
      end
      checks++;
      if (fo !== fd[w*FW +: FW]) begin
        failures++; $display("FAIL rnd_frame frame=%0d got=%h want=%h", f, fo, fd[w*FW +: FW]);
      end
      checks++;
      if (ge !== ee) begin failures++; $display("FAIL rnd_timing frame=%0d got=%0d want=%0d", f, ge, ee); end
      checks++;
      if (a !== (4'b0001 << w) || a2 !== 4'b0000) begin
        failures++; $display("FAIL rnd_ack frame=%0d got=%b/%b want_src=%0d", f, a, a2, w);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_send();
    int n, ee, ge, hb;
    logic [NS-1:0] g, a, a2;
    logic [FW-1:0] fo, foe;
    logic [NS*FW-1:0] fd;
    logic gp, gs;
    req = 4'b0100;
    n = 0;
    while (grant === '0 && n < 300) begin
      tick();
      n++;
    end
    checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL mid_grant got=%b want=0100", grant); end
    req = '0;
    tick();
    tick();
    checks++; if (busy !== 1'b1 || go !== 1'b1) begin
      failures++; $display("FAIL mid_send_state busy=%b go=%b want=1/1", busy, go);
    end
    reset = 1'b1;
    tick();
    checks++; if (go !== 1'b0) begin failures++; $display("FAIL mid_rst_go got=%b want=0", go); end
    checks++; if (grant !== '0) begin failures++; $display("FAIL mid_rst_grant got=%b want=0", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    checks++; if (frame_out !== '0) begin failures++; $display("FAIL mid_rst_frame got=%h want=0", frame_out); end
    reset = 1'b0;
    ret_done = 1'b1;
    exp_ptr = 0;
    last_s = -1000;
    last_ret_exit = -1000;
    run_frame(4'b1010, 1'b1, 1'b0, 1, 0, ee, ge, g, fo, fd, gp, foe, gs, a, a2, hb);
    checks++; if (g !== 4'b0010) begin failures++; $display("FAIL mid_ptr_reset got=%b want=0010", g); end
    checks++; if (ge !== ee) begin failures++; $display("FAIL mid_regrant got=%0d want=%0d", ge, ee); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_gap();
    test_stability();
    test_ret_hold();
    test_random();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_arbiter.md
# led_frame_arbiter

Round-robin scheduler that shares the single WS2812B serial output path among up to eight frame sources. It sits between the pattern sources and the LED control/shift-register/bit-generator chain. Each granted frame is latched and presented as a 96-bit word (4 LEDs × 24-bit GRB). The block drives the `go` strobe, then waits for `sendDone` and `retDone` before the next grant. A programmable minimum frame gap limits the refresh rate.

## Interface
- `NUM_SRC`, 4, number of requesting sources (2..8)
- `FRAME_W`, 96, frame width in bits (4 LEDs × 24)
- `FRAME_GAP`, 1000000, minimum clocks from `sendDone` to next grant (10 ms at 100 MHz); 0 disables

- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req`  in  NUM_SRC  per-source frame request, level
- `frameData`  in  NUM_SRC*FRAME_W  source i occupies bits [i*FRAME_W +: FRAME_W]
- `sendDone`  in  1  full frame shifted out (from send counter)
- `retDone`  in  1  reset/latch time satisfied (from ret counter)
- `grant`  out  NUM_SRC  one-hot owner of current frame, 0 when idle
- `frameOut`  out  FRAME_W  latched frame feeding shift register
- `go`  out  1  start-send strobe to LED control, registered
- `ack`  out  NUM_SRC  one-cycle pulse to owner when its frame is sent
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, GRANT, SEND, RET.
- IDLE: if `|req`, gap counter == 0 and `retDone` → GRANT; else stay.
- Arbitration in IDLE, round-robin. The search starts at `ptr`, the index after the last winner, and the first asserted `req` wins. `ptr` resets to 0, so source 0 has highest priority after reset.
- GRANT (1 cycle): latch the winner's `frameData` into `frameOut`. Set `grant` one-hot. Set `ptr` = winner+1 (mod NUM_SRC). → SEND.
- SEND: `go`=1. On `sendDone`: pulse `ack[winner]`, load gap counter with FRAME_GAP, → RET.
- RET: `go`=0, `grant` held. On `retDone` → IDLE, `grant` cleared.
- Gap counter: width `$clog2(FRAME_GAP+1)`. Decrements each cycle while nonzero, in any state, and saturates at 0.
- `req` dropped after GRANT: the frame still completes and `ack` still pulses. `req` dropped before GRANT: no grant.
- `frameData` changes after GRANT have no effect on `frameOut` until the next grant.
- `sendDone` and `retDone` high together in SEND: → RET, then → IDLE on the next cycle if `retDone` is still high.
- `sendDone` outside SEND and `retDone` outside RET/IDLE are ignored.
- Reset mid-operation: next edge forces IDLE; `go`, `grant`, `ack` and the gap counter go to 0; `frameOut` goes to 0; `ptr` goes to 0.

## Timing
- Reset values: `grant`=0, `frameOut`=0, `go`=0, `ack`=0, `busy`=0, state=IDLE.
- Latency:
  - `req` seen high at edge N (IDLE, gap 0, `retDone` high): GRANT after N, `grant`/`frameOut` valid after N+1, `go` high after N+1.
  - `sendDone` high at edge M: `go` low and `ack` high after M; `ack` low after M+1.
- All outputs are registered; no combinational input-to-output paths.
- Back-to-back frames are separated by at least max(FRAME_GAP, RET duration) + 1 cycles.

## Structure
- Shared package `led_pkg`:
  - state encoding localparams: IDLE=2'd0, GRANT=2'd1, SEND=2'd2, RET=2'd3
  - `LED_BITS`=24, `LEDS_PER_FRAME`=4, `FRAME_W` derived from these
- Sub-module `led_rr_pick`:
  - combinational round-robin selector
  - inputs `req`, `ptr`; outputs `winner` index and `found`
  - reused by any future LED-resource arbiter
- Top module holds the state machine, gap counter, `ptr`, and the frame latch and mux.

## Test plan
- Single source: `req`=4'b0001, `frameData[0]`=96'hFF0000_00FF00_0000FF_FFFFFF, FRAME_GAP=0. Expect:
  - `grant`=0001 and `frameOut` equal to that value 2 cycles after `req`
  - `go` high until `sendDone`, then `ack[0]` single-cycle pulse
- Fairness: `req`=4'b1111 held, FRAME_GAP=0. Grant order 0,1,2,3,0; each source acked exactly once per 4 frames.
- Frame gap: FRAME_GAP=20, continuous `req[1]`, `retDone` immediate. Next `grant` no earlier than 21 cycles after `sendDone`.
- Data stability:
  - change `frameData[2]` during SEND → `frameOut` unchanged
  - drop `req[2]` during SEND → `ack[2]` still pulses
- `retDone` held low 50 cycles after the frame: block stays in RET/IDLE with no grant, then grants on the cycle after `retDone` rises.
- Reset asserted mid-SEND: next edge `go`=0, `grant`=0, `busy`=0. After release with `req`=4'b1010, the first grant goes to source 1 (`ptr` reset to 0).
